cu_param: RTL

Parametrised multi-cycle control unit for the mycpu datapath. It generalises register-address width, adds a ready/wait handshake with timeout on memory and I/O accesses, a generalised three-step absolute-difference sequence (ABS) on any register triple, and a halt/resume mechanism with a sticky error flag. It sits between the instruction register and the PC, register file, ALU, memory and I/O muxes.

---
 rtl/mycpu_pkg.sv | 70 +++++++
 rtl/cu_wait_cnt.sv | 28 ++
 rtl/cu_param.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the mycpu control unit.
// Opcode map, ALU function codes, PC select codes and instruction classes.
package mycpu_pkg;

    typedef enum logic [2:0] {
        RST, INF, EX0, AB1, AB2, HLT
    } cu_state_t;

    typedef enum logic [6:0] {
        OP_MOVA = 7'h00,
        OP_INC  = 7'h01,
        OP_ADD  = 7'h02,
        OP_SUB  = 7'h05,
        OP_DEC  = 7'h06,
        OP_AND  = 7'h08,
        OP_OR   = 7'h09,
        OP_XOR  = 7'h0A,
        OP_NOT  = 7'h0B,
        OP_MOVB = 7'h0C,
        OP_SHR  = 7'h0D,
        OP_SHL  = 7'h0E,
        OP_CLR  = 7'h0F,
        OP_LD   = 7'h10,
        OP_IOR  = 7'h11,
        OP_ST   = 7'h20,
        OP_IOW  = 7'h21,
        OP_ABS  = 7'h30,
        OP_ADI  = 7'h42,
        OP_LDI  = 7'h4C,
        OP_BRZ  = 7'h60,
        OP_BRN  = 7'h61,
        OP_JMP  = 7'h70,
        OP_HAL  = 7'h7F
    } opcode_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_BR, C_JMP, C_MEM, C_ABS, C_HAL, C_ILL
    } op_class_t;

    localparam logic [3:0] FSUB = 4'b0101;
    localparam logic [3:0] FNOT = 4'b1011;
    localparam logic [3:0] FINC = 4'b0001;
    localparam logic [3:0] FDEF = 4'b1111;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    // Register ALU ops occupy the whole 000xxxx page.
    function automatic op_class_t op_class(input logic [6:0] op);
        op_class_t c;
        c = C_ILL;
        if (op[6:4] == 3'b000) begin
            c = C_ALU;
        end else begin
            case (op)
                OP_LDI, OP_ADI:               c = C_IMM;
                OP_BRZ, OP_BRN:               c = C_BR;
                OP_JMP:                       c = C_JMP;
                OP_LD, OP_ST, OP_IOR, OP_IOW: c = C_MEM;
                OP_ABS:                       c = C_ABS;
                OP_HAL:                       c = C_HAL;
                default:                      c = C_ILL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/cu_wait_cnt.sv
// Memory/I/O wait-cycle counter.
// Terminal count flags the timeout limit; a zero limit never fires.
module cu_wait_cnt #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (MAX != 0) && (r_cnt == W'(MAX));

endmodule

// File: rtl/cu_param.sv
// Multi-cycle control unit: fetch/execute sequencing, memory waits
// with timeout, ABS micro-sequence and halt/resume with sticky error.
module cu_param
    import mycpu_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7+3*REG_AW-1:0]     ins_in,
    input  logic                      z_in,
    input  logic                      n_in,
    input  logic                      rdy_in,
    input  logic                      run_in,
    output logic                      il_out,
    output logic [1:0]                ps_out,
    output logic                      rw_out,
    output logic [3*(REG_AW+1)-1:0]   rs_out,
    output logic                      mm_out,
    output logic [1:0]                md_out,
    output logic                      mb_out,
    output logic [3:0]                fs_out,
    output logic                      wen_out,
    output logic                      iom_out,
    output logic                      halted_out,
    output logic                      err_out
);
    localparam int RS_W  = REG_AW + 1;
    localparam int INS_W = 7 + 3*REG_AW;

    cu_state_t r_state;
    cu_state_t w_next;
    logic      r_err;
    logic      w_set_err;
    logic      w_tc;
    logic      w_cnt_en;
    op_class_t w_cls;

    logic [6:0]        w_op;
    logic [REG_AW-1:0] w_d;
    logic [REG_AW-1:0] w_a;
    logic [REG_AW-1:0] w_b;
    logic [3*RS_W-1:0] w_rs_dab;
    logic [3*RS_W-1:0] w_rs_ddd;
    logic              w_is_ld;
    logic              w_is_ior;
    logic              w_is_io;
    logic              w_is_wr;
    logic              w_take;

    assign w_op  = ins_in[INS_W-1 -: 7];
    assign w_d   = ins_in[3*REG_AW-1 -: REG_AW];
    assign w_a   = ins_in[2*REG_AW-1 -: REG_AW];
    assign w_b   = ins_in[REG_AW-1:0];
    assign w_cls = op_class(w_op);

    assign w_rs_dab = {1'b0, w_d, 1'b0, w_a, 1'b0, w_b};
    assign w_rs_ddd = {1'b0, w_d, 1'b0, w_d, 1'b0, w_d};

    assign w_is_ld  = (w_op == OP_LD);
    assign w_is_ior = (w_op == OP_IOR);
    assign w_is_io  = w_is_ior || (w_op == OP_IOW);
    assign w_is_wr  = (w_op == OP_ST) || (w_op == OP_IOW);
    assign w_take   = (w_op == OP_BRZ) ? z_in : n_in;

    assign w_cnt_en = (r_state == EX0) && (w_cls == C_MEM) && !rdy_in;

    cu_wait_cnt #(
        .MAX (WAIT_MAX)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != EX0),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        il_out     = 1'b0;
        ps_out     = PS_HOLD;
        rw_out     = 1'b0;
        rs_out     = '0;
        mm_out     = 1'b0;
        md_out     = 2'b00;
        mb_out     = 1'b0;
        fs_out     = FDEF;
        wen_out    = 1'b1;
        iom_out    = 1'b0;
        halted_out = 1'b0;
        unique case (r_state)
            RST: w_next = INF;
            INF: begin
                il_out = 1'b1;
                mm_out = 1'b1;
                w_next = EX0;
            end
            EX0: begin
                rs_out = w_rs_dab;
                w_next = INF;
                unique case (w_cls)
                    C_ALU, C_IMM: begin
                        ps_out = PS_INC;
                        rw_out = 1'b1;
                        fs_out = w_op[3:0];
                        mb_out = (w_cls == C_IMM);
                    end
                    C_BR: begin
                        ps_out = w_take ? PS_BR : PS_INC;
                        fs_out = 4'b0000;
                    end
                    C_JMP: begin
                        ps_out = PS_JMP;
                        fs_out = 4'b0000;
                    end
                    C_MEM: begin
                        iom_out = w_is_io;
                        wen_out = !w_is_wr;
                        if (rdy_in) begin
                            ps_out = PS_INC;
                            rw_out = w_is_ld || w_is_ior;
                            if (w_is_ld)       md_out = 2'b01;
                            else if (w_is_ior) md_out = 2'b10;
                        end else if (w_tc) begin
                            w_set_err = 1'b1;
                            w_next    = HLT;
                        end else begin
                            w_next = EX0;
                        end
                    end
                    C_ABS: begin
                        ps_out = PS_INC;
                        rw_out = 1'b1;
                        fs_out = FSUB;
                        w_next = n_in ? AB1 : INF;
                    end
                    C_HAL: begin
                        ps_out = PS_INC;
                        w_next = HLT;
                    end
                    default: begin
                        rs_out    = '0;
                        w_set_err = 1'b1;
                        w_next    = HLT;
                    end
                endcase
            end
            AB1: begin
                rs_out = w_rs_ddd;
                fs_out = FNOT;
                rw_out = 1'b1;
                w_next = AB2;
            end
            AB2: begin
                rs_out = w_rs_ddd;
                fs_out = FINC;
                rw_out = 1'b1;
                w_next = INF;
            end
            HLT: begin
                halted_out = 1'b1;
                if (run_in && !r_err) w_next = INF;
            end
            default: w_next = RST;
        endcase
    end

    assign err_out = r_err;

endmodule
